reg_file_sweep: RTL and testbench

//  Parametrised CPU register file: DATA_W-bit registers, 2**ADDR_W entries, one write

---
 rtl/reg_file_sweep.sv | 57 +++++
 tb/tb_reg_file_sweep.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_sweep.sv
// reg_file_sweep: 2-read/1-write register file with a one-entry-per-cycle clear sweep.
// Optional macro REGFILE_BYPASS_EN forwards an IDLE write to matching read ports.
module reg_file_sweep #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] writereg,
  input  logic              writeenable,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  input  logic              clear,
  output logic [DATA_W-1:0] regout1,
  output logic [DATA_W-1:0] regout2,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic wr_ok, fwd1, fwd2;
  assign wr_ok = writeenable && !(ZERO_R0 && writereg == '0);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == IDLE) begin
      if (wr_ok) regs[writereg] <= writedata;
      if (clear) begin
        state <= SWEEP;
        cnt <= '0;
        busy <= 1'b1;
      end
    end else begin
      regs[cnt] <= '0;
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
`ifdef REGFILE_BYPASS_EN
  assign fwd1 = state == IDLE && wr_ok && readreg1 == writereg;
  assign fwd2 = state == IDLE && wr_ok && readreg2 == writereg;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  assign regout1 = (ZERO_R0 && readreg1 == '0) ? '0 : fwd1 ? writedata : regs[readreg1];
  assign regout2 = (ZERO_R0 && readreg2 == '0) ? '0 : fwd2 ? writedata : regs[readreg2];
endmodule

// File: tb/tb_reg_file_sweep.sv
// tb_reg_file_sweep: directed checks of reg_file_sweep against an array model, ZERO_R0 0 and 1.
module tb_reg_file_sweep;
  logic clk = 0, reset = 1, we = 0, clr = 0;
  logic [7:0] wd = 0;
  logic [2:0] wa = 0, ra1 = 0, ra2 = 0;
  logic [7:0] o1, o2, z1, z2;
  logic bsy, zb;
  int vecs = 0, errs = 0;
  logic [7:0] m0 [8] = '{default: 8'd0};
  logic [7:0] m1 [8] = '{default: 8'd0};
  int left = 0;
  always #5 clk = ~clk;
  reg_file_sweep u0 (.clk(clk), .reset(reset), .writedata(wd), .writereg(wa), .writeenable(we),
    .readreg1(ra1), .readreg2(ra2), .clear(clr), .regout1(o1), .regout2(o2), .busy(bsy));
  reg_file_sweep #(.ZERO_R0(1'b1)) u1 (.clk(clk), .reset(reset), .writedata(wd), .writereg(wa),
    .writeenable(we), .readreg1(ra1), .readreg2(ra2), .clear(clr), .regout1(z1), .regout2(z2),
    .busy(zb));
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1; wa = a; wd = d;
    tick();
    we = 0;
  endtask
  // left counts sweep edges still to come; the next one zeroes entry 8-left
  always @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 8; i++) begin m0[i] = 0; m1[i] = 0; end
      left = 0;
    end else if (left > 0) begin
      m0[8-left] = 0;
      m1[8-left] = 0;
      left--;
    end else begin
      if (we) begin
        m0[wa] = wd;
        if (wa != 0) m1[wa] = wd;
      end
      if (clr) left = 8;
    end
  function automatic logic [7:0] exp_rd(input bit z, input logic [2:0] a);
    if (z && a == 0) return 8'd0;
`ifdef REGFILE_BYPASS_EN
    if (left == 0 && we && a == wa) return wd;
`endif
    return z ? m1[a] : m0[a];
  endfunction
  always @(negedge clk) begin
    chk("out1", o1, exp_rd(0, ra1));
    chk("out2", o2, exp_rd(0, ra2));
    chk("busy", {7'd0, bsy}, {7'd0, left > 0});
    chk("z_out1", z1, exp_rd(1, ra1));
    chk("z_out2", z2, exp_rd(1, ra2));
    chk("z_busy", {7'd0, zb}, {7'd0, left > 0});
  end
  initial begin
    #100000;
    $display("FAIL watchdog: run still going at %0t, required finish", $time);
    $fatal(1);
  end
  initial begin
    int n;
    wd = 8'($urandom); wa = 3'($urandom); we = 1'($urandom);
    ra1 = 3'($urandom); ra2 = 3'($urandom); clr = 1'($urandom);
    #1;
    chk("rst_out1", o1, 0);
    chk("rst_out2", o2, 0);
    chk("rst_busy", {7'd0, bsy}, 0);
    tick(); tick();
    reset = 0; we = 0; clr = 0; wd = 0; wa = 0;
    wr(1, 28);
    wr(7, 50);
    ra1 = 1; ra2 = 7;
    #1;
    chk("wr_r1", o1, 28);
    chk("wr_r7", o2, 50);
    wa = 1; wd = 15; we = 0;
    tick();
    chk("no_we_r1", o1, 28);
    #2 reset = 1;
    #1;
    chk("async_rst_out1", o1, 0);
    chk("async_rst_out2", o2, 0);
    tick();
    reset = 0;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(i + 1));
    ra1 = 2; ra2 = 3;
    clr = 1;
    tick();
    clr = 0;
    n = 0;
    while (bsy && n < 20) begin
      n++;
      tick();
      if (n == 3) begin
        chk("sweep3_r2", o1, 0);
        chk("sweep3_r3", o2, 4);
      end
    end
    chk("sweep_busy_cycles", 8'(n), 8);
    chk("sweep_end_r3", o2, 0);
    wr(5, 5);
    ra1 = 5; ra2 = 3;
    clr = 1;
    tick();
    clr = 0;
    n = 0;
    while (bsy && n < 20) begin
      n++;
      if (n == 7) begin we = 1; wa = 5; wd = 99; clr = 1; end
      else begin we = 0; clr = 0; end
      tick();
    end
    we = 0; clr = 0;
    chk("collide_busy_cycles", 8'(n), 8);
    chk("collide_r5", o1, 0);
    we = 1; wa = 3; wd = 77; clr = 1;
    tick();
    we = 0; clr = 0;
    chk("same_edge_r3", o2, 77);
    n = 0;
    while (bsy && n < 20) begin n++; tick(); end
    chk("same_edge_cycles", 8'(n), 8);
    chk("same_edge_end_r3", o2, 0);
    wr(7, 70);
    ra1 = 7; ra2 = 4;
    clr = 1;
    tick();
    clr = 0;
    tick(); tick(); tick();
    #2 reset = 1;
    #1;
    chk("midsweep_busy", {7'd0, bsy}, 0);
    chk("midsweep_r7", o1, 0);
    tick();
    reset = 0;
    wr(4, 33);
    chk("post_rst_r4", o2, 33);
    wr(0, 15);
    ra1 = 0;
    #1;
    chk("r0_plain", o1, 15);
    chk("r0_zero", z1, 0);
    wr(2, 10);
    we = 1; wa = 2; wd = 42; ra1 = 2;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_pre_edge", o1, 42);
`else
    chk("nobypass_pre_edge", o1, 10);
`endif
    tick();
    we = 0;
    chk("post_edge_r2", o1, 42);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
